phold_engine: RTL and testbench

- Hardware PHOLD parallel-discrete-event benchmark engine.
- Keeps a fixed pool of pending events.
- Repeatedly processes the event with the lowest timestamp: read-modify-writes that LP's state counter in memory through a Convey-style memory-controller port, then reschedules the event with a pseudo-random delay and destination.
- Publishes GVT and raises a completion flag once GVT reaches SIM_END_TIME; the host side waits on that flag.

---
 rtl/phold_engine.sv | 225 ++++++++++++++++++++++
 tb/tb_phold_engine.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phold_engine.sv
// PHOLD event engine: retires the earliest pending event by incrementing its
// target LP counter through MC port 0, then reschedules it pseudo-randomly.
module phold_engine #(
  parameter int unsigned NUM_MC_PORTS    = 1,
  parameter int unsigned SIM_END_TIME    = 1000,
  parameter int unsigned MC_RTNCTL_WIDTH = 32,
  parameter int unsigned TIME_WID        = 16,
  parameter int unsigned NUM_LP          = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [47:0]                addr,
  output logic [TIME_WID-1:0]        gvt,
  output logic                       rtn_vld,
  output logic                       mc_rq_vld,
  output logic [2:0]                 mc_rq_cmd,
  output logic [3:0]                 mc_rq_scmd,
  output logic [47:0]                mc_rq_vadr,
  output logic [1:0]                 mc_rq_size,
  output logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl,
  output logic [63:0]                mc_rq_data,
  output logic                       mc_rq_flush,
  input  logic                       mc_rq_stall,
  input  logic                       mc_rs_vld,
  input  logic [2:0]                 mc_rs_cmd,
  input  logic [3:0]                 mc_rs_scmd,
  input  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl,
  input  logic [63:0]                mc_rs_data,
  output logic                       mc_rs_stall
);
  localparam int unsigned LP_W = (NUM_LP > 1) ? $clog2(NUM_LP) : 1;
  localparam int unsigned TW1  = TIME_WID + 1;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [2:0] {
    S_INIT, S_SCAN, S_RD_REQ, S_RD_WAIT, S_WR_REQ, S_WR_WAIT, S_UPDATE, S_DONE
  } state_e;

  state_e                     state_q, state_d;
  logic [LP_W-1:0]            scan_idx_q, scan_idx_d;
  logic [TIME_WID-1:0]        min_time_q, min_time_d;
  logic [LP_W-1:0]            min_idx_q, min_idx_d;
  logic [LP_W-1:0]            sel_q, sel_d;
  logic [LP_W-1:0]            dest_q, dest_d;
  logic [TIME_WID-1:0]        gvt_q, gvt_d;
  logic                       rtn_vld_q, rtn_vld_d;
  logic [15:0]                lfsr_q, lfsr_d;
  logic [TIME_WID-1:0]        pool_time_q [NUM_LP];
  logic [TIME_WID-1:0]        pool_time_d [NUM_LP];
  logic [LP_W-1:0]            pool_dest_q [NUM_LP];
  logic [LP_W-1:0]            pool_dest_d [NUM_LP];
  logic                       rq_vld_q, rq_vld_d;
  logic [2:0]                 rq_cmd_q, rq_cmd_d;
  logic [47:0]                rq_vadr_q, rq_vadr_d;
  logic [1:0]                 rq_size_q, rq_size_d;
  logic [MC_RTNCTL_WIDTH-1:0] rq_rtnctl_q, rq_rtnctl_d;
  logic [63:0]                rq_data_q, rq_data_d;

  logic [TIME_WID-1:0] cur_time_c, best_time_c;
  logic [LP_W-1:0]     best_idx_c, tgt_c;
  logic [47:0]         vadr_c;
  logic [15:0]         lfsr_nxt_c;
  logic [TW1-1:0]      new_time_c;
  logic                rs_tag_hit_c;
  logic                unused_c;

  // Scan datapath: running minimum including this cycle's entry; ties keep the lower index
  always_comb begin
    cur_time_c = pool_time_q[scan_idx_q];
    if ((scan_idx_q == '0) || (cur_time_c < min_time_q)) begin
      best_time_c = cur_time_c;
      best_idx_c  = scan_idx_q;
    end else begin
      best_time_c = min_time_q;
      best_idx_c  = min_idx_q;
    end
    tgt_c        = (state_q == S_SCAN) ? pool_dest_q[best_idx_c] : dest_q;
    vadr_c       = addr + 48'({tgt_c, 3'b000});
    rs_tag_hit_c = mc_rs_vld && (mc_rs_rtnctl == MC_RTNCTL_WIDTH'(tgt_c));
    lfsr_nxt_c   = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    new_time_c   = {1'b0, pool_time_q[sel_q]} + TW1'(lfsr_nxt_c[7:4]) + TW1'(1);
  end

  always_comb begin
    state_d     = state_q;
    scan_idx_d  = scan_idx_q;
    min_time_d  = min_time_q;
    min_idx_d   = min_idx_q;
    sel_d       = sel_q;
    dest_d      = dest_q;
    gvt_d       = gvt_q;
    rtn_vld_d   = rtn_vld_q;
    lfsr_d      = lfsr_q;
    pool_time_d = pool_time_q;
    pool_dest_d = pool_dest_q;
    rq_vld_d    = rq_vld_q;
    rq_cmd_d    = rq_cmd_q;
    rq_vadr_d   = rq_vadr_q;
    rq_size_d   = 2'd3;
    rq_rtnctl_d = rq_rtnctl_q;
    rq_data_d   = rq_data_q;
    case (state_q)
      S_INIT: begin
        scan_idx_d = '0;
        state_d    = S_SCAN;
      end
      S_SCAN: begin
        scan_idx_d = scan_idx_q + LP_W'(1);
        min_time_d = best_time_c;
        min_idx_d  = best_idx_c;
        if (scan_idx_q == LP_W'(NUM_LP - 1)) begin
          gvt_d  = best_time_c;
          sel_d  = best_idx_c;
          dest_d = tgt_c;
          if (best_time_c >= TIME_WID'(SIM_END_TIME)) begin
            rtn_vld_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            rq_vld_d    = 1'b1;
            rq_cmd_d    = 3'd1;
            rq_vadr_d   = vadr_c;
            rq_rtnctl_d = MC_RTNCTL_WIDTH'(tgt_c);
            rq_data_d   = 64'd0;
            state_d     = S_RD_REQ;
          end
        end
      end
      S_RD_REQ, S_WR_REQ: begin
        // Request fields hold until the MC takes them
        if (!mc_rq_stall) begin
          rq_vld_d    = 1'b0;
          rq_cmd_d    = 3'd0;
          rq_vadr_d   = 48'd0;
          rq_rtnctl_d = '0;
          rq_data_d   = 64'd0;
          if (state_q == S_RD_REQ) state_d = S_RD_WAIT;
          else                     state_d = S_WR_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (rs_tag_hit_c && (mc_rs_cmd == 3'd2)) begin
          rq_vld_d    = 1'b1;
          rq_cmd_d    = 3'd2;
          rq_vadr_d   = vadr_c;
          rq_rtnctl_d = MC_RTNCTL_WIDTH'(dest_q);
          rq_data_d   = mc_rs_data + 64'd1;
          state_d     = S_WR_REQ;
        end
      end
      S_WR_WAIT: begin
        if (rs_tag_hit_c && (mc_rs_cmd == 3'd3)) state_d = S_UPDATE;
      end
      S_UPDATE: begin
        // Reschedule with the freshly advanced LFSR: delay 1..16, saturating
        lfsr_d             = lfsr_nxt_c;
        pool_time_d[sel_q] = new_time_c[TIME_WID] ? '1 : new_time_c[TIME_WID-1:0];
        pool_dest_d[sel_q] = lfsr_nxt_c[LP_W-1:0];
        state_d            = S_SCAN;
      end
      S_DONE: begin
        rtn_vld_d = 1'b1;
        rq_vld_d  = 1'b0;
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_INIT;
      scan_idx_q  <= '0;
      min_time_q  <= '0;
      min_idx_q   <= '0;
      sel_q       <= '0;
      dest_q      <= '0;
      gvt_q       <= '0;
      rtn_vld_q   <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      for (int i = 0; i < int'(NUM_LP); i++) begin
        pool_time_q[i] <= '0;
        pool_dest_q[i] <= LP_W'(i);
      end
      rq_vld_q    <= 1'b0;
      rq_cmd_q    <= 3'd0;
      rq_vadr_q   <= 48'd0;
      rq_size_q   <= 2'd0;
      rq_rtnctl_q <= '0;
      rq_data_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      scan_idx_q  <= scan_idx_d;
      min_time_q  <= min_time_d;
      min_idx_q   <= min_idx_d;
      sel_q       <= sel_d;
      dest_q      <= dest_d;
      gvt_q       <= gvt_d;
      rtn_vld_q   <= rtn_vld_d;
      lfsr_q      <= lfsr_d;
      pool_time_q <= pool_time_d;
      pool_dest_q <= pool_dest_d;
      rq_vld_q    <= rq_vld_d;
      rq_cmd_q    <= rq_cmd_d;
      rq_vadr_q   <= rq_vadr_d;
      rq_size_q   <= rq_size_d;
      rq_rtnctl_q <= rq_rtnctl_d;
      rq_data_q   <= rq_data_d;
    end
  end

  assign gvt          = gvt_q;
  assign rtn_vld      = rtn_vld_q;
  assign mc_rq_vld    = rq_vld_q;
  assign mc_rq_cmd    = rq_cmd_q;
  assign mc_rq_scmd   = 4'd0;
  assign mc_rq_vadr   = rq_vadr_q;
  assign mc_rq_size   = rq_size_q;
  assign mc_rq_rtnctl = rq_rtnctl_q;
  assign mc_rq_data   = rq_data_q;
  assign mc_rq_flush  = 1'b0;
  assign mc_rs_stall  = 1'b0;

  // Only port 0 exists here and the response sub-command carries nothing we need
  assign unused_c = ^{mc_rs_scmd, 1'(NUM_MC_PORTS)};
endmodule

// File: tb/tb_phold_engine.sv
`timescale 1ns/1ps
// Directed bench for phold_engine: scenario tasks drive a behavioural MC memory
// and compare the engine against an independent event-pool/LFSR model.
module tb_phold_engine;
  localparam int NUM_LP   = 8;
  localparam int TIME_WID = 16;
  localparam int RTN_W    = 32;
  localparam int SIM_END  = 1000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [47:0]         addr;
  logic [TIME_WID-1:0] gvt;
  logic                rtn_vld;
  logic                mc_rq_vld;
  logic [2:0]          mc_rq_cmd;
  logic [3:0]          mc_rq_scmd;
  logic [47:0]         mc_rq_vadr;
  logic [1:0]          mc_rq_size;
  logic [RTN_W-1:0]    mc_rq_rtnctl;
  logic [63:0]         mc_rq_data;
  logic                mc_rq_flush;
  logic                mc_rq_stall;
  logic                mc_rs_vld;
  logic [2:0]          mc_rs_cmd;
  logic [3:0]          mc_rs_scmd;
  logic [RTN_W-1:0]    mc_rs_rtnctl;
  logic [63:0]         mc_rs_data;
  logic                mc_rs_stall;

  phold_engine #(
    .NUM_MC_PORTS(1), .SIM_END_TIME(SIM_END), .MC_RTNCTL_WIDTH(RTN_W),
    .TIME_WID(TIME_WID), .NUM_LP(NUM_LP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .gvt(gvt), .rtn_vld(rtn_vld),
    .mc_rq_vld(mc_rq_vld), .mc_rq_cmd(mc_rq_cmd), .mc_rq_scmd(mc_rq_scmd),
    .mc_rq_vadr(mc_rq_vadr), .mc_rq_size(mc_rq_size), .mc_rq_rtnctl(mc_rq_rtnctl),
    .mc_rq_data(mc_rq_data), .mc_rq_flush(mc_rq_flush), .mc_rq_stall(mc_rq_stall),
    .mc_rs_vld(mc_rs_vld), .mc_rs_cmd(mc_rs_cmd), .mc_rs_scmd(mc_rs_scmd),
    .mc_rs_rtnctl(mc_rs_rtnctl), .mc_rs_data(mc_rs_data), .mc_rs_stall(mc_rs_stall)
  );

  always #5 clk = ~clk;

  int errors;
  int checks;

  logic [63:0]      ram [128];
  bit               stall_hold;
  bit               corrupt_tag;
  bit               wrong_sent;
  bit               rsp_pending;
  int               rsp_delay;
  logic [2:0]       rsp_cmd;
  logic [RTN_W-1:0] rsp_tag;
  logic [63:0]      rsp_data;
  bit               acc_vld;
  logic [2:0]       acc_cmd;
  logic [47:0]      acc_vadr;
  logic [RTN_W-1:0] acc_tag;
  logic [63:0]      acc_data;
  int               n_reads;
  int               n_writes;

  logic [15:0] m_time [NUM_LP];
  logic [2:0]  m_dest [NUM_LP];
  logic [15:0] m_lfsr;

  task automatic model_init();
    for (int i = 0; i < NUM_LP; i++) begin
      m_time[i] = 16'd0;
      m_dest[i] = 3'(i);
    end
    m_lfsr = 16'hACE1;
  endtask

  function automatic int model_min();
    int s = 0;
    for (int i = 1; i < NUM_LP; i++) if (m_time[i] < m_time[s]) s = i;
    return s;
  endfunction

  task automatic model_step(input int s);
    int t;
    m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
    t = int'(m_time[s]) + int'(m_lfsr[7:4]) + 1;
    m_time[s] = (t > 65535) ? 16'hFFFF : 16'(t);
    m_dest[s] = m_lfsr[2:0];
  endtask

  // One MC cycle, evaluated on the falling edge: respond, then stall or accept
  task automatic tick();
    @(negedge clk);
    mc_rs_vld  = 1'b0;
    acc_vld    = 1'b0;
    wrong_sent = 1'b0;
    if (rsp_pending) begin
      if (rsp_delay > 0) rsp_delay--;
      else begin
        mc_rs_vld  = 1'b1;
        mc_rs_cmd  = rsp_cmd;
        mc_rs_data = rsp_data;
        if (corrupt_tag) begin
          mc_rs_rtnctl = rsp_tag ^ 32'h1;
          corrupt_tag  = 1'b0;
          wrong_sent   = 1'b1;
          rsp_delay    = 2;
        end else begin
          mc_rs_rtnctl = rsp_tag;
          rsp_pending  = 1'b0;
        end
      end
    end
    mc_rq_stall = stall_hold;
    if (mc_rq_vld && !mc_rq_stall) begin
      acc_vld  = 1'b1;
      acc_cmd  = mc_rq_cmd;
      acc_vadr = mc_rq_vadr;
      acc_tag  = mc_rq_rtnctl;
      acc_data = mc_rq_data;
      if (mc_rq_cmd == 3'd1) begin
        rsp_cmd  = 3'd2;
        rsp_data = ram[mc_rq_vadr[9:3]];
        n_reads++;
      end else begin
        ram[mc_rq_vadr[9:3]] = mc_rq_data;
        rsp_cmd  = 3'd3;
        rsp_data = 64'd0;
        n_writes++;
      end
      rsp_tag     = mc_rq_rtnctl;
      rsp_pending = 1'b1;
      rsp_delay   = 1;
    end
  endtask

  task automatic wait_acc(input int limit, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < limit; n++) begin
      tick();
      if (acc_vld) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic clear_ram();
    for (int i = 0; i < 128; i++) ram[i] = 64'd0;
  endtask

  task automatic test_reset();
    int lat;
    rst_n = 1'b0;
    addr = 48'd0;
    stall_hold = 1'b1;
    clear_ram();
    repeat (3) tick();
    checks++;
    if (mc_rq_vld !== 1'b0 || gvt !== 16'd0 || rtn_vld !== 1'b0 || mc_rq_cmd !== 3'd0) begin
      errors++;
      $display("FAIL reset_outputs: vld=%b gvt=%0d rtn=%b cmd=%0d expected all 0", mc_rq_vld, gvt, rtn_vld, mc_rq_cmd);
    end
    rst_n = 1'b1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mc_rq_vld && lat < 50);
    checks++;
    if (lat != 9) begin
      errors++;
      $display("FAIL first_req_latency: got %0d cycles expected 9", lat);
    end
    checks++;
    if (mc_rq_vld !== 1'b1 || mc_rq_cmd !== 3'd1 || mc_rq_vadr !== 48'd0 || mc_rq_rtnctl !== 32'd0 ||
        mc_rq_size !== 2'd3 || mc_rq_scmd !== 4'd0 || mc_rq_flush !== 1'b0 || mc_rq_data !== 64'd0) begin
      errors++;
      $display("FAIL first_req: vld=%b cmd=%0d vadr=%h tag=%0d size=%0d data=%h expected 1,1,0,0,3,0",
               mc_rq_vld, mc_rq_cmd, mc_rq_vadr, mc_rq_rtnctl, mc_rq_size, mc_rq_data);
    end
    checks++;
    if (gvt !== 16'd0 || rtn_vld !== 1'b0 || mc_rs_stall !== 1'b0) begin
      errors++;
      $display("FAIL first_req_status: gvt=%0d rtn=%b rs_stall=%b expected 0,0,0", gvt, rtn_vld, mc_rs_stall);
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (mc_rq_vld !== 1'b1 || mc_rq_cmd !== 3'd1 || mc_rq_vadr !== 48'd0 || mc_rq_rtnctl !== 32'd0) begin
        errors++;
        $display("FAIL stall_hold%0d: vld=%b cmd=%0d vadr=%h tag=%0d expected 1,1,0,0",
                 i, mc_rq_vld, mc_rq_cmd, mc_rq_vadr, mc_rq_rtnctl);
      end
    end
    stall_hold = 1'b0;
    n_reads = 0;
    n_writes = 0;
    tick();
    checks++;
    if (!acc_vld || n_reads != 1) begin
      errors++;
      $display("FAIL stall_release: accepted=%b reads=%0d expected 1,1", acc_vld, n_reads);
    end
    corrupt_tag = 1'b1;
  endtask

  task automatic test_wrong_tag();
    int n = 0;
    while (!wrong_sent && n < 10) begin
      tick();
      n++;
    end
    checks++;
    if (!wrong_sent) begin
      errors++;
      $display("FAIL wrong_tag_inject: response not sent within %0d cycles", n);
    end
    tick();
    checks++;
    if (mc_rq_vld !== 1'b0 || n_writes != 0) begin
      errors++;
      $display("FAIL wrong_tag_ignored: vld=%b writes=%0d expected 0,0", mc_rq_vld, n_writes);
    end
  endtask

  task automatic test_first_event();
    bit ok;
    wait_acc(20, ok);
    checks++;
    if (!ok || acc_cmd !== 3'd2 || acc_vadr !== 48'd0 || acc_tag !== 32'd0 || acc_data !== 64'd1 || n_reads != 1) begin
      errors++;
      $display("FAIL first_write: ok=%b cmd=%0d vadr=%h tag=%0d data=%0d reads=%0d expected 1,2,0,0,1,1",
               ok, acc_cmd, acc_vadr, acc_tag, acc_data, n_reads);
    end
    repeat (5) tick();
    model_init();
    model_step(0);
    checks++;
    if (dut.pool_time_q[0] !== m_time[0] || dut.pool_time_q[0] < 16'd1 || dut.pool_time_q[0] > 16'd16 ||
        dut.pool_dest_q[0] !== m_dest[0]) begin
      errors++;
      $display("FAIL pool0_reschedule: time=%0d dest=%0d expected time=%0d dest=%0d",
               dut.pool_time_q[0], dut.pool_dest_q[0], m_time[0], m_dest[0]);
    end
  endtask

  task automatic test_reset_mid();
    bit found = 1'b0;
    int lat;
    for (int n = 0; n < 3000 && !found; n++) begin
      tick();
      if (acc_vld && acc_cmd == 3'd1 && gvt != 16'd0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_setup: no read with nonzero gvt, gvt=%0d expected >0", gvt);
    end
    tick();
    stall_hold = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mc_rq_vld !== 1'b0 || gvt !== 16'd0 || rtn_vld !== 1'b0 || mc_rq_vadr !== 48'd0 || mc_rq_data !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_async: vld=%b gvt=%0d rtn=%b vadr=%h data=%h expected all 0",
               mc_rq_vld, gvt, rtn_vld, mc_rq_vadr, mc_rq_data);
    end
    #1 rst_n = 1'b1;
    clear_ram();
    n_writes = 0;
    n_reads = 0;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!mc_rq_vld && lat < 50);
    checks++;
    if (lat != 9 || mc_rq_cmd !== 3'd1 || mc_rq_vadr !== 48'd0 || mc_rq_rtnctl !== 32'd0 ||
        mc_rq_size !== 2'd3 || gvt !== 16'd0 || rtn_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_restart: lat=%0d cmd=%0d vadr=%h tag=%0d size=%0d gvt=%0d expected 9,1,0,0,3,0",
               lat, mc_rq_cmd, mc_rq_vadr, mc_rq_rtnctl, mc_rq_size, gvt);
    end
  endtask

  task automatic test_free_run();
    int          sel;
    int          ev = 0;
    int          rises = 0;
    int          late_rq = 0;
    bit          ok;
    bit          bad = 1'b0;
    logic [47:0] exp_vadr;
    logic [63:0] exp_wdata;
    logic [63:0] sum = 64'd0;
    logic [15:0] end_time;
    model_init();
    stall_hold = 1'b0;
    forever begin
      sel = model_min();
      if (m_time[sel] >= 16'(SIM_END) || ev >= 5000 || bad) break;
      exp_vadr = addr + 48'({m_dest[sel], 3'b000});
      wait_acc(200, ok);
      checks++;
      if (!ok || acc_cmd !== 3'd1 || acc_vadr !== exp_vadr || acc_tag !== 32'(m_dest[sel]) ||
          gvt !== m_time[sel] || rtn_vld !== 1'b0) begin
        errors++;
        bad = 1'b1;
        $display("FAIL run_read ev%0d: ok=%b cmd=%0d vadr=%h tag=%0d gvt=%0d rtn=%b expected cmd=1 vadr=%h tag=%0d gvt=%0d rtn=0",
                 ev, ok, acc_cmd, acc_vadr, acc_tag, gvt, rtn_vld, exp_vadr, m_dest[sel], m_time[sel]);
      end
      exp_wdata = ram[m_dest[sel]] + 64'd1;
      wait_acc(200, ok);
      checks++;
      if (!ok || acc_cmd !== 3'd2 || acc_vadr !== exp_vadr || acc_tag !== 32'(m_dest[sel]) || acc_data !== exp_wdata) begin
        errors++;
        bad = 1'b1;
        $display("FAIL run_write ev%0d: ok=%b cmd=%0d vadr=%h tag=%0d data=%0d expected cmd=2 vadr=%h tag=%0d data=%0d",
                 ev, ok, acc_cmd, acc_vadr, acc_tag, acc_data, exp_vadr, m_dest[sel], exp_wdata);
      end
      model_step(sel);
      ev++;
    end
    end_time = m_time[model_min()];
    ok = 1'b0;
    for (int n = 0; n < 60 && !ok; n++) begin
      tick();
      if (acc_vld) late_rq++;
      if (rtn_vld) ok = 1'b1;
    end
    if (ok) rises = 1;
    checks++;
    if (!ok || gvt !== end_time || gvt < 16'(SIM_END) || gvt > 16'(SIM_END + 15)) begin
      errors++;
      $display("FAIL run_done: rtn=%b gvt=%0d expected rtn=1 gvt=%0d in [%0d,%0d]",
               rtn_vld, gvt, end_time, SIM_END, SIM_END + 15);
    end
    for (int n = 0; n < 40; n++) begin
      tick();
      if (mc_rq_vld) late_rq++;
      if (!rtn_vld) rises = 2;
    end
    checks++;
    if (late_rq != 0 || rises != 1) begin
      errors++;
      $display("FAIL run_quiet: late_requests=%0d rtn_state=%0d expected 0 and 1", late_rq, rises);
    end
    for (int i = 0; i < NUM_LP; i++) sum += ram[i];
    checks++;
    if (sum !== 64'(n_writes) || n_writes != ev) begin
      errors++;
      $display("FAIL run_counter_sum: sum=%0d writes=%0d events=%0d expected all equal", sum, n_writes, ev);
    end
  endtask

  initial begin
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b0;
    addr         = 48'd0;
    mc_rq_stall  = 1'b0;
    mc_rs_vld    = 1'b0;
    mc_rs_cmd    = 3'd0;
    mc_rs_scmd   = 4'd0;
    mc_rs_rtnctl = '0;
    mc_rs_data   = 64'd0;
    stall_hold   = 1'b0;
    corrupt_tag  = 1'b0;
    wrong_sent   = 1'b0;
    rsp_pending  = 1'b0;
    rsp_delay    = 0;
    acc_vld      = 1'b0;
    n_reads      = 0;
    n_writes     = 0;
    test_reset();
    test_stall();
    test_wrong_tag();
    test_first_event();
    test_reset_mid();
    test_free_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
